aes_byte_display_scheduler: RTL and testbench
=============================================

AES_BYTE_DISPLAY_SCHEDULER -- requirements
Module: aes_byte_display_scheduler

Interface
REQ-001 The block SHALL have parameter DWELL, default 50000000, giving the number of clock cycles each byte is displayed (legal range 1 to 2^32-1).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port data_in, input, 128 bits, the AES block to display; byte k is data_in[8k+7:8k].
REQ-005 The block SHALL have port data_valid, input, 1 bit, which qualifies data_in.
REQ-006 The block SHALL have port data_ready, output, 1 bit, asserted when the block accepts a new block.
REQ-007 The block SHALL have port step, input, 1 bit, a single-cycle request to advance to the next byte.
REQ-008 The block SHALL have port hold, input, 1 bit, which freezes the dwell timer while high.
REQ-009 The block SHALL have port byte_idx, output, 4 bits, the index of the byte currently displayed.
REQ-010 The block SHALL have port cur_byte, output, 8 bits, the value of the byte currently displayed.
REQ-011 The block SHALL have ports Seg1, Seg2, Seg3, output, 7 bits each, active-low segments for ones, tens and hundreds.
REQ-012 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last byte's dwell ends.

Function
REQ-014 The FSM SHALL have states IDLE, CONVERT and SHOW; data_ready = 1 only in IDLE.
REQ-015 In IDLE with data_valid=1, the block SHALL capture data_in into a 128-bit register, set byte_idx=0 and enter CONVERT on the same edge; data_valid SHALL be ignored outside IDLE.
REQ-016 cur_byte SHALL equal captured byte byte_idx at all times after the first capture.
REQ-017 CONVERT SHALL run a sequential shift-and-add-3 binary-to-BCD conversion of cur_byte lasting exactly 8 cycles: add 3 to any BCD nibble >= 5, then shift left one bit.
REQ-018 On the edge ending the 8th CONVERT cycle, the block SHALL latch ones/tens/hundreds (hundreds 0..2), update Seg1..Seg3, clear the dwell counter and enter SHOW.
REQ-019 The segment encoding SHALL be 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000.
REQ-020 Seg1..Seg3 SHALL stay stable throughout CONVERT, showing the previous byte and never an intermediate value.
REQ-021 In SHOW, the dwell counter SHALL increment each cycle with hold=0 and hold its value with hold=1.
REQ-022 SHOW SHALL end on the edge where the counter reaches DWELL-1 with hold=0, or on any edge with step=1; step SHALL override hold.
REQ-023 On SHOW end with byte_idx<15, the block SHALL increment byte_idx and enter CONVERT.
REQ-024 On SHOW end with byte_idx=15, the block SHALL pulse done for one cycle, enter IDLE, keep byte_idx=15 and keep the segment outputs unchanged.
REQ-025 step SHALL be ignored in IDLE and CONVERT; it SHALL NOT be queued.
REQ-026 Per-byte period SHALL be 8+DWELL cycles without step; a full block SHALL take 16*(8+DWELL) cycles from capture to done.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-CONVERT or mid-SHOW, and abandon any partial conversion.
REQ-028 Reset values SHALL be: data_ready=1, busy=0, done=0, byte_idx=0, cur_byte=0, data register=0, dwell counter=0, and Seg1=Seg2=Seg3=1111111 (blank).
REQ-029 rst SHALL take priority over data_valid and step on the same edge.

Verification
REQ-030 The bench SHALL cover basic conversion: DWELL=4, data_in byte0=0x7B, data_valid pulse -> after 8 cycles Seg3=1111001, Seg2=0100100, Seg1=0110000 (123), held 4 cycles, then byte_idx=1.
REQ-031 The bench SHALL cover extremes: byte0=0x00 -> 000 (all segments 1000000); byte1=0xFF -> Seg3=0100100, Seg2=0010010, Seg1=0010010 (255).
REQ-032 The bench SHALL cover a full sequence: DWELL=3, no step -> done pulses exactly 176 cycles after capture, data_ready=1 the following cycle, byte_idx=15.
REQ-033 The bench SHALL cover hold/step: hold=1 in SHOW for 20 cycles -> byte_idx unchanged; step=1 while hold=1 -> CONVERT next cycle; step during CONVERT -> no effect.
REQ-034 The bench SHALL cover busy protection: data_valid with a new block while busy -> data ignored, displayed bytes still come from the first block.
REQ-035 The bench SHALL cover reset mid-operation: rst during CONVERT of byte 5 -> next cycle IDLE, segments blank, byte_idx=0, data_ready=1.

Source files
------------

// File: rtl/aes_byte_display_scheduler.sv
// rtl/aes_byte_display_scheduler.sv - steps through the 16 bytes of an AES block, showing each as three decimal digits
module aes_byte_display_scheduler #(
    parameter int unsigned DWELL = 32'd50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic         step,
    input  logic         hold,
    output logic [3:0]   byte_idx,
    output logic [7:0]   cur_byte,
    output logic [6:0]   Seg1,
    output logic [6:0]   Seg2,
    output logic [6:0]   Seg3,
    output logic         busy,
    output logic         done
);

    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
    localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SHOW    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   data_q;
    logic [3:0]     idx_q;
    logic [2:0]     bit_cnt_q;
    logic [19:0]    sr_q;
    logic [31:0]    dwell_q;
    logic [6:0]     seg1_q, seg2_q, seg3_q;
    logic           done_q;

    logic [7:0]     cur_byte_w;
    logic [19:0]    dd_in;
    logic [19:0]    dd_out;
    logic           capture;
    logic           conv_last;
    logic           show_end;
    logic           last_byte;

    // One double-dabble iteration on {hundreds, tens, ones, binary}:
    // correct every BCD nibble that would overflow on doubling, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5) begin
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // Active-low seven-segment pattern, bit 6 = segment g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign cur_byte_w = data_q[{idx_q, 3'b000} +: 8];
    // The first conversion cycle pulls the operand straight from the byte
    // mux, so no separate load cycle is needed and CONVERT is exactly 8 long.
    assign dd_in      = (bit_cnt_q == 3'd0) ? {12'd0, cur_byte_w} : sr_q;
    assign dd_out     = dd_step(dd_in);

    assign capture    = (state_q == S_IDLE) && data_valid;
    assign conv_last  = (state_q == S_CONVERT) && (bit_cnt_q == 3'd7);
    assign show_end   = (state_q == S_SHOW) && (step || (!hold && (dwell_q == DWELL_LAST)));
    assign last_byte  = (idx_q == 4'd15);

    // State register; reset abandons whatever was in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (conv_last) begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (show_end) begin
                    state_d = last_byte ? S_IDLE : S_CONVERT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        data_ready = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
    end

    // Block capture, byte index, BCD conversion, segment latch and dwell timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            dwell_q   <= '0;
            seg1_q    <= SEG_BLANK;
            seg2_q    <= SEG_BLANK;
            seg3_q    <= SEG_BLANK;
            done_q    <= 1'b0;
        end else begin
            done_q <= show_end && last_byte;

            if (capture) begin
                data_q    <= data_in;
                idx_q     <= 4'd0;
                bit_cnt_q <= 3'd0;
            end

            if (state_q == S_CONVERT) begin
                sr_q      <= dd_out;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (conv_last) begin
                    seg1_q  <= seg7(dd_out[11:8]);
                    seg2_q  <= seg7(dd_out[15:12]);
                    seg3_q  <= seg7(dd_out[19:16]);
                    dwell_q <= 32'd0;
                end
            end

            if (state_q == S_SHOW) begin
                if (show_end) begin
                    dwell_q <= 32'd0;
                    if (!last_byte) begin
                        idx_q     <= idx_q + 4'd1;
                        bit_cnt_q <= 3'd0;
                    end
                end else if (!hold) begin
                    dwell_q <= dwell_q + 32'd1;
                end
            end
        end
    end

    assign byte_idx = idx_q;
    assign cur_byte = cur_byte_w;
    assign Seg1     = seg1_q;
    assign Seg2     = seg2_q;
    assign Seg3     = seg3_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_byte_display_scheduler.sv
// tb/tb_aes_byte_display_scheduler.sv - self-checking bench with a decimal-arithmetic reference model
module tb_aes_byte_display_scheduler;

    localparam int A_DWELL = 3;
    localparam int B_DWELL = 4;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A (DWELL=3): model-checked every cycle
    logic         a_rst, a_valid, a_step, a_hold;
    logic [127:0] a_data;
    logic         a_ready, a_busy, a_done;
    logic [3:0]   a_idx;
    logic [7:0]   a_cur;
    logic [6:0]   a_seg1, a_seg2, a_seg3;

    // DUT B (DWELL=4): directed basic-conversion scenario
    logic         b_rst, b_valid, b_step, b_hold;
    logic [127:0] b_data;
    logic         b_ready, b_busy, b_done;
    logic [3:0]   b_idx;
    logic [7:0]   b_cur;
    logic [6:0]   b_seg1, b_seg2, b_seg3;

    aes_byte_display_scheduler #(.DWELL(A_DWELL)) dut_a (
        .clk(clk), .rst(a_rst), .data_in(a_data), .data_valid(a_valid),
        .data_ready(a_ready), .step(a_step), .hold(a_hold), .byte_idx(a_idx),
        .cur_byte(a_cur), .Seg1(a_seg1), .Seg2(a_seg2), .Seg3(a_seg3),
        .busy(a_busy), .done(a_done)
    );

    aes_byte_display_scheduler #(.DWELL(B_DWELL)) dut_b (
        .clk(clk), .rst(b_rst), .data_in(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .step(b_step), .hold(b_hold), .byte_idx(b_idx),
        .cur_byte(b_cur), .Seg1(b_seg1), .Seg2(b_seg2), .Seg3(b_seg3),
        .busy(b_busy), .done(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
        return tab[d];
    endfunction

    // Reference model: mode 0 idle, 1 converting (m_t cycles so far), 2 showing
    int          m_mode, m_t, m_idx, m_dwell;
    logic [7:0]  m_blk [16];
    logic [6:0]  m_seg1, m_seg2, m_seg3;
    logic        m_done;

    task automatic model_step();
        int v;
        if (a_rst) begin
            m_mode = 0; m_t = 0; m_idx = 0; m_dwell = 0; m_done = 1'b0;
            for (int k = 0; k < 16; k++) m_blk[k] = 8'h00;
            m_seg1 = SB; m_seg2 = SB; m_seg3 = SB;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                0: if (a_valid) begin
                    for (int k = 0; k < 16; k++) m_blk[k] = a_data[8*k +: 8];
                    m_idx = 0; m_t = 0; m_mode = 1;
                end
                1: begin
                    m_t++;
                    if (m_t == 8) begin
                        v = int'(m_blk[m_idx]);
                        m_seg1 = seg_of(v % 10);
                        m_seg2 = seg_of((v / 10) % 10);
                        m_seg3 = seg_of(v / 100);
                        m_dwell = 0; m_mode = 2;
                    end
                end
                default: begin
                    if (a_step || (!a_hold && m_dwell == A_DWELL - 1)) begin
                        m_dwell = 0;
                        if (m_idx == 15) begin
                            m_mode = 0; m_done = 1'b1;
                        end else begin
                            m_idx++; m_t = 0; m_mode = 1;
                        end
                    end else if (!a_hold) begin
                        m_dwell++;
                    end
                end
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    // Compare DUT A against the model every cycle, away from the edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model",
                  {a_idx, a_cur, a_seg3, a_seg2, a_seg1, a_busy, a_ready, a_done},
                  {4'(m_idx), m_blk[m_idx], m_seg3, m_seg2, m_seg1,
                   (m_mode != 0), (m_mode == 0), m_done});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture_a(input logic [127:0] d);
        a_data  = d;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (!a_ready && n < 2000) begin
            tick();
            n++;
        end
        check("idle_timeout", 36'(a_ready), 36'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [127:0] blk;
        a_rst = 1'b1; a_valid = 1'b0; a_step = 1'b0; a_hold = 1'b0; a_data = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_step = 1'b0; b_hold = 1'b0; b_data = '0;
        tick(); tick();
        chk_en = 1'b1;
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset values
        check("rst_a", {a_idx, a_cur, a_seg3, a_seg2, a_seg1, a_busy, a_ready, a_done},
              {4'd0, 8'd0, SB, SB, SB, 1'b0, 1'b1, 1'b0});
        check("rst_b", {b_idx, b_cur, b_seg3, b_seg2, b_seg1, b_busy, b_ready, b_done},
              {4'd0, 8'd0, SB, SB, SB, 1'b0, 1'b1, 1'b0});

        // Basic conversion on B: 0x7B -> 123, held 4 cycles
        b_data = {112'h0, 8'h45, 8'h7B};
        b_valid = 1'b1; tick(); b_valid = 1'b0;
        repeat (8) tick();
        check("b_123", 36'({b_seg3, b_seg2, b_seg1}), 36'({S1, S2, S3}));
        for (int i = 0; i < B_DWELL; i++) begin
            check("b_hold_idx", 36'(b_idx), 36'd0);
            tick();
        end
        check("b_next_idx", 36'(b_idx), 36'd1);

        // Extremes and full sequence on A
        blk = {$urandom, $urandom, $urandom, 16'(($urandom)), 8'hFF, 8'h00};
        capture_a(blk);
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (n == 8)
                check("seg_000", 36'({a_seg3, a_seg2, a_seg1}), 36'({S0, S0, S0}));
            if (n == 19) begin
                check("seg_255", 36'({a_seg3, a_seg2, a_seg1}), 36'({S2, S5, S5}));
                check("model_255", 36'({m_seg3, m_seg2, m_seg1}), 36'({S2, S5, S5}));
            end
            if (a_done) break;
        end
        check("done_latency", 36'(n), 36'd176);
        check("done_state", 36'({a_ready, a_idx}), 36'({1'b1, 4'd15}));
        tick();
        check("after_done", 36'({a_ready, a_done, a_idx}), 36'({1'b1, 1'b0, 4'd15}));
        check("segs_kept", 36'({a_seg3, a_seg2, a_seg1}), 36'(seg_of(int'(blk[127:120]) / 100)) << 14
              | 36'(seg_of((int'(blk[127:120]) / 10) % 10)) << 7 | 36'(seg_of(int'(blk[127:120]) % 10)));

        // Hold freezes, step overrides hold, step in CONVERT is dropped
        capture_a({$urandom, $urandom, $urandom, $urandom});
        repeat (8) tick();
        a_hold = 1'b1;
        repeat (20) tick();
        check("hold_idx", 36'(a_idx), 36'd0);
        a_step = 1'b1; tick(); a_step = 1'b0; a_hold = 1'b0;
        check("step_over_hold", 36'({a_idx, a_busy}), 36'({4'd1, 1'b1}));
        repeat (2) tick();
        a_step = 1'b1; tick(); a_step = 1'b0;
        repeat (5) tick();
        tick();
        check("step_not_queued", 36'(a_idx), 36'd1);
        wait_idle_a();

        // New block while busy is ignored
        capture_a({$urandom, $urandom, $urandom, 16'(($urandom)), 8'h22, 8'h11});
        repeat (3) tick();
        a_data = {4{32'hDEADBEEF}}; a_valid = 1'b1; tick(); a_valid = 1'b0;
        check("busy_byte0", 36'(a_cur), 36'h11);
        repeat (4) tick();
        a_step = 1'b1; tick(); a_step = 1'b0;
        check("busy_byte1", 36'(a_cur), 36'h22);
        wait_idle_a();

        // Reset during CONVERT of byte 5
        capture_a({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 5; i++) begin
            repeat (8) tick();
            a_step = 1'b1; tick(); a_step = 1'b0;
        end
        repeat (3) tick();
        check("pre_rst", 36'({a_idx, a_busy}), 36'({4'd5, 1'b1}));
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        check("mid_rst", {a_idx, a_cur, a_seg3, a_seg2, a_seg1, a_busy, a_ready, a_done},
              {4'd0, 8'd0, SB, SB, SB, 1'b0, 1'b1, 1'b0});

        // Randomised traffic, checked only by the model
        for (int i = 0; i < 1500; i++) begin
            a_hold  = ($urandom_range(0, 3) == 0);
            a_step  = ($urandom_range(0, 7) == 0);
            a_valid = ($urandom_range(0, 4) == 0);
            a_data  = {$urandom, $urandom, $urandom, $urandom};
            a_rst   = ($urandom_range(0, 499) == 0);
            tick();
        end
        a_hold = 1'b0; a_step = 1'b0; a_valid = 1'b0; a_rst = 1'b0;
        wait_idle_a();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
